key_trigger_ctrl: RTL and testbench

- Upstream front end for sound_generator.
- Takes a raw mechanical push-button, synchronises and debounces it, and issues one trigger per press on `trig`, which drives the generator's `key1` input.
- Handshakes with the generator's `ready` output so a press is never lost and never retriggers mid-tone.
- Reports press/drop counts and status LEDs.

---
 rtl/key_trigger_pkg.sv | 15 +
 rtl/key_debounce.sv | 54 +++++
 rtl/key_trigger_ctrl.sv | 117 +++++++++++
 tb/tb_key_trigger_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_trigger_pkg.sv
// Shared types and constants for the push-button trigger front end.
package key_trigger_pkg;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    WAIT_ACK,
    WAIT_DONE,
    RELEASE
  } trig_state_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronises the raw button pin, applies pin polarity and debounces the level.
// press_evt pulses for one cycle on each accepted released->pressed change.
module key_debounce
  import key_trigger_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter logic        KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic level,
  output logic press_evt
);

  localparam logic [15:0] DEB_TERM = DEBOUNCE_CYCLES - 16'd1;
  // Sync flops come out of reset holding the released pin level, so a short
  // debounce setting cannot see a phantom press right after reset.
  localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{KEY_ACTIVE_LOW}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [15:0]            deb_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= SYNC_RST;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt   <= '0;
      level     <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (synced == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_TERM) begin
        deb_cnt   <= '0;
        level     <= synced;
        press_evt <= synced;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/key_trigger_ctrl.sv
// Button-to-tone trigger controller: one trig per debounced press, handshaked
// against the generator's ready, with press/drop counters and status outputs.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a debounced press
//   FIRE      | press accepted; trig is raised on leaving this state
//   WAIT_ACK  | trig held high until gen_ready rises or the ack timer expires
//   WAIT_DONE | tone playing; waiting for gen_ready to fall
//   RELEASE   | waiting for the debounced key release (no auto-repeat)
module key_trigger_ctrl
  import key_trigger_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter logic [15:0] ACK_TIMEOUT     = 16'd64,
  parameter logic        KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_raw,
  input  logic             gen_ready,
  output logic             trig,
  output logic             busy,
  output logic             led0,
  output logic             fault,
  output logic [CNT_W-1:0] press_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam logic [15:0] TMO_TERM = ACK_TIMEOUT - 16'd1;

  trig_state_t      state_q, state_d;
  logic             trig_d, fault_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [CNT_W-1:0] press_d, drop_d;
  logic             level, press_evt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_deb (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_raw  (key_raw),
    .level    (level),
    .press_evt(press_evt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      trig        <= 1'b0;
      fault       <= 1'b0;
      tmo_q       <= '0;
      press_count <= '0;
      drop_count  <= '0;
    end else begin
      state_q     <= state_d;
      trig        <= trig_d;
      fault       <= fault_d;
      tmo_q       <= tmo_d;
      press_count <= press_d;
      drop_count  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    trig_d  = trig;
    fault_d = fault;
    tmo_d   = tmo_q;
    press_d = press_count;
    drop_d  = drop_count;

    // A press outside IDLE is only counted; the drop counter saturates.
    if (press_evt && (state_q != IDLE) && (drop_count != {CNT_W{1'b1}})) begin
      drop_d = drop_count + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (press_evt) begin
          state_d = FIRE;
          press_d = press_count + 1'b1;
        end
      end
      FIRE: begin
        trig_d  = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (gen_ready) begin
          trig_d  = 1'b0;
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_TERM) begin
          trig_d  = 1'b0;
          fault_d = 1'b1;
          state_d = RELEASE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!gen_ready) state_d = RELEASE;
      end
      RELEASE: begin
        if (!level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign led0 = level;

endmodule

// File: tb/tb_key_trigger_ctrl.sv
// Directed bench for key_trigger_ctrl with a simple sound_generator ready model.
module tb_key_trigger_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_raw;
  logic       gen_ready = 1'b0;
  logic       trig, busy, led0, fault;
  logic [7:0] press_count, drop_count;

  logic gen_auto = 1'b0;
  int   gen_cnt  = 0;
  int   gen_dly  = 0;

  int checks = 0;
  int errors = 0;

  key_trigger_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .ACK_TIMEOUT    (16'd8),
    .KEY_ACTIVE_LOW (1'b1)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .gen_ready  (gen_ready),
    .trig       (trig),
    .busy       (busy),
    .led0       (led0),
    .fault      (fault),
    .press_count(press_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Generator model: ready rises one cycle after trig is seen, stays 20 cycles.
  always @(posedge clk) begin
    #2;
    if (!gen_auto) begin
      gen_ready = 1'b0;
      gen_cnt   = 0;
      gen_dly   = 0;
    end else if (gen_cnt > 0) begin
      gen_cnt = gen_cnt - 1;
      if (gen_cnt == 0) gen_ready = 1'b0;
    end else if (gen_dly > 0) begin
      gen_dly = gen_dly - 1;
      if (gen_dly == 0) begin
        gen_ready = 1'b1;
        gen_cnt   = 20;
      end
    end else if (trig && !gen_ready) begin
      gen_dly = 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      step(1);
      n++;
    end
    check("wait_idle", 16'(busy), 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    key_raw = 1'b1;
    #1;
    check("rst_trig",  16'(trig), 16'd0);
    check("rst_busy",  16'(busy), 16'd0);
    check("rst_led0",  16'(led0), 16'd0);
    check("rst_fault", 16'(fault), 16'd0);
    check("rst_press", 16'(press_count), 16'd0);
    check("rst_drop",  16'(drop_count), 16'd0);
    step(2);
    reset_n  = 1'b1;
    gen_auto = 1'b1;
    step(3);

    // Clean press, held 50 cycles.
    key_raw = 1'b0;
    step(5);
    check("c_led0_pre", 16'(led0), 16'd0);
    step(1);
    check("c_led0_rise", 16'(led0), 16'd1);
    check("c_busy_pre", 16'(busy), 16'd0);
    step(1);
    check("c_busy_fire", 16'(busy), 16'd1);
    check("c_press", 16'(press_count), 16'd1);
    check("c_trig_fire", 16'(trig), 16'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (trig) n++;
    end
    check("c_trig_len", 16'(n), 16'd2);
    step(39);
    check("c_busy_held", 16'(busy), 16'd1);
    check("c_trig_held", 16'(trig), 16'd0);
    key_raw = 1'b1;
    step(6);
    check("c_led0_fall", 16'(led0), 16'd0);
    check("c_busy_rel", 16'(busy), 16'd1);
    step(1);
    check("c_busy_idle", 16'(busy), 16'd0);
    check("c_fault", 16'(fault), 16'd0);

    // Bounce then hold low.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      key_raw = ~key_raw;
      step(2);
    end
    check("b_led0_bounce", 16'(led0), 16'd0);
    check("b_press_bounce", 16'(press_count), 16'd0);
    key_raw = 1'b0;
    step(30);
    check("b_press", 16'(press_count), 16'd1);
    check("b_drop", 16'(drop_count), 16'd0);
    check("b_led0", 16'(led0), 16'd1);
    key_raw = 1'b1;
    wait_idle(50);

    // Press again while the tone is still playing.
    do_reset();
    key_raw = 1'b0;
    step(12);
    key_raw = 1'b1;
    step(7);
    key_raw = 1'b0;
    step(8);
    check("t_trig", 16'(trig), 16'd0);
    check("t_drop", 16'(drop_count), 16'd1);
    check("t_press", 16'(press_count), 16'd1);
    step(13);
    check("t_trig_hold", 16'(trig), 16'd0);
    check("t_busy_hold", 16'(busy), 16'd1);
    check("t_press_hold", 16'(press_count), 16'd1);
    key_raw = 1'b1;
    wait_idle(50);

    // Ack timeout with ready stuck low.
    do_reset();
    gen_auto = 1'b0;
    key_raw  = 1'b0;
    step(7);
    check("a_trig_pre", 16'(trig), 16'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (trig) n++;
    end
    check("a_trig_len", 16'(n), 16'd8);
    step(1);
    check("a_trig_drop", 16'(trig), 16'd0);
    check("a_fault", 16'(fault), 16'd1);
    step(10);
    check("a_fault_sticky", 16'(fault), 16'd1);
    check("a_busy_held", 16'(busy), 16'd1);
    key_raw = 1'b1;
    step(7);
    check("a_busy_idle", 16'(busy), 16'd0);
    gen_auto = 1'b1;
    key_raw  = 1'b0;
    step(8);
    check("a_refire", 16'(trig), 16'd1);
    check("a_fault_keep", 16'(fault), 16'd1);
    check("a_press", 16'(press_count), 16'd2);
    key_raw = 1'b1;
    wait_idle(60);

    // Reset while waiting for the ack.
    gen_auto = 1'b0;
    key_raw  = 1'b0;
    step(9);
    check("r_trig_pre", 16'(trig), 16'd1);
    reset_n = 1'b0;
    #1;
    check("r_trig", 16'(trig), 16'd0);
    check("r_busy", 16'(busy), 16'd0);
    check("r_fault", 16'(fault), 16'd0);
    check("r_press", 16'(press_count), 16'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    key_raw = 1'b1;
    step(10);
    check("r_busy_after", 16'(busy), 16'd0);
    gen_auto = 1'b1;
    key_raw  = 1'b0;
    step(8);
    check("r_refire", 16'(trig), 16'd1);
    check("r_press_after", 16'(press_count), 16'd1);
    key_raw = 1'b1;
    wait_idle(60);

    // 256 complete press/tone cycles.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      key_raw = 1'b0;
      step(10);
      key_raw = 1'b1;
      wait_idle(100);
    end
    check("w_press_255", 16'(press_count), 16'd255);
    key_raw = 1'b0;
    step(10);
    key_raw = 1'b1;
    wait_idle(100);
    check("w_press_wrap", 16'(press_count), 16'd0);
    check("w_drop", 16'(drop_count), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
